// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int set_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
        return addr_w - $clog2(sets) - $clog2(line_words);
    endfunction

    // Lowest-index invalid way wins; with every way valid fall back to round robin.
    // Unused way slots must be passed in as valid.
    function automatic logic [1:0] pick_victim(input logic [3:0] valid, input logic [1:0] rr);
        logic [1:0] v;
        v = rr;
        for (int w = 3; w >= 0; w--)
            if (!valid[w]) v = 2'(w);
        return v;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-fill signals of the instruction cache.
interface icache_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              req;
    logic [ADDR_W-1:0] addr_in;
    logic              flush;
    logic [DATA_W-1:0] inst_out;
    logic              busy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;

    modport master (
        output req, addr_in, flush, mem_data, mem_ack,
        input  inst_out, busy, mem_req, mem_addr
    );

    modport slave (
        input  req, addr_in, flush, mem_data, mem_ack,
        output inst_out, busy, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_way.sv
// One cache way: line data array, per-set tag and valid bit; one write and one read port.
module icache_way import icache_pkg::*; #(
    parameter int DATA_W     = 16,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 5,
    localparam int SET_W     = set_bits(SETS),
    localparam int OFF_W     = off_bits(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inv_all,
    input  logic              wr_en,
    input  logic [SET_W-1:0]  wr_set,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  tag_wdata,
    input  logic [SET_W-1:0]  rd_set,
    input  logic [OFF_W-1:0]  rd_off,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid
);
    logic [DATA_W-1:0] data_q [SETS*LINE_WORDS];
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [SETS-1:0]   valid_q;

    always_ff @(posedge clk)
        if (wr_en) data_q[{wr_set, wr_off}] <= wr_data;

    always_ff @(posedge clk)
        if (tag_we) tag_q[wr_set] <= tag_wdata;

    // Invalidate wins over a same-edge line install.
    always_ff @(posedge clk)
        if (rst || inv_all) valid_q <= '0;
        else if (tag_we)    valid_q[wr_set] <= 1'b1;

    assign rd_data  = data_q[{rd_set, rd_off}];
    assign rd_tag   = tag_q[rd_set];
    assign rd_valid = valid_q[rd_set];
endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with handshaked line fill and flush.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache_assoc import icache_pkg::*; #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 8,
    parameter int WAYS       = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    icache_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int OFF_W = off_bits(LINE_WORDS);
    localparam int SET_W = set_bits(SETS);
    localparam int TAG_W = tag_bits(ADDR_W, SETS, LINE_WORDS);

    state_t                  state;
    logic [TAG_W-1:0]        l_tag;
    logic [SET_W-1:0]        l_set;
    logic [OFF_W-1:0]        l_off, cnt;
    logic [1:0]              victim;
    logic                    flush_pend;
    logic [SETS-1:0][1:0]    rr_ptr;

    logic [OFF_W-1:0]        a_off;
    logic [SET_W-1:0]        a_set;
    logic [TAG_W-1:0]        a_tag;
    logic [SET_W-1:0]        rd_set;
    logic [OFF_W-1:0]        rd_off;

    logic [WAYS-1:0][DATA_W-1:0] rd_data;
    logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
    logic [WAYS-1:0]             rd_valid, hit_way, wr_en;
    logic [DATA_W-1:0]           hit_data, fill_data;
    logic [3:0]                  valid4;
    logic [1:0]                  vsel;
    logic                        ack, last, inv_all, hit;

    assign a_off = bus.addr_in[OFF_W-1:0];
    assign a_set = bus.addr_in[OFF_W +: SET_W];
    assign a_tag = bus.addr_in[ADDR_W-1 -: TAG_W];

    // Lookups read at the incoming address; DONE reads back the freshly filled word.
    assign rd_set  = (state == IDLE) ? a_set : l_set;
    assign rd_off  = (state == IDLE) ? a_off : l_off;
    assign ack     = clk_en && (state == FILL) && bus.mem_ack;
    assign last    = (cnt == OFF_W'(LINE_WORDS-1));
    assign inv_all = clk_en && (((state == IDLE) && bus.flush) ||
                                ((state == DONE) && (flush_pend || bus.flush)));

    always_comb begin
        hit_way   = '0;
        wr_en     = '0;
        hit_data  = '0;
        fill_data = '0;
        valid4    = '1;
        for (int w = 0; w < WAYS; w++) begin
            hit_way[w] = rd_valid[w] && (rd_tag[w] == a_tag);
            if (hit_way[w]) hit_data = hit_data | rd_data[w];
            if (victim == 2'(w)) fill_data = rd_data[w];
            valid4[w] = rd_valid[w];
            wr_en[w]  = ack && (victim == 2'(w));
        end
    end

    // A flush alongside a request forces a miss; every way is invalid after it.
    assign hit  = (|hit_way) && !bus.flush;
    assign vsel = bus.flush ? 2'd0 : pick_victim(valid4, rr_ptr[a_set]);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .DATA_W(DATA_W), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .inv_all  (inv_all),
            .wr_en    (wr_en[w]),
            .wr_set   (l_set),
            .wr_off   (cnt),
            .wr_data  (bus.mem_data),
            .tag_we   (wr_en[w] && last),
            .tag_wdata(l_tag),
            .rd_set   (rd_set),
            .rd_off   (rd_off),
            .rd_data  (rd_data[w]),
            .rd_tag   (rd_tag[w]),
            .rd_valid (rd_valid[w])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.inst_out <= '0;
            l_tag        <= '0;
            l_set        <= '0;
            l_off        <= '0;
            cnt          <= '0;
            victim       <= '0;
            flush_pend   <= 1'b0;
            rr_ptr       <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: if (bus.req) begin
                    if (hit) bus.inst_out <= hit_data;
                    else begin
                        l_tag  <= a_tag;
                        l_set  <= a_set;
                        l_off  <= a_off;
                        victim <= vsel;
                        cnt    <= '0;
                        state  <= FILL;
                    end
                end
                FILL: begin
                    if (bus.flush) flush_pend <= 1'b1;
                    if (bus.mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            rr_ptr[l_set] <= (rr_ptr[l_set] == 2'(WAYS-1)) ? 2'd0
                                                                          : rr_ptr[l_set] + 2'd1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.inst_out <= fill_data;
                    flush_pend   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE) && clk_en;
    assign bus.mem_req  = (state == FILL) && clk_en;
    assign bus.mem_addr = (state == FILL) ? {l_tag, l_set, cnt} : '0;

`ifdef ICACHE_STATS_EN
    logic lookup;
    assign lookup = clk_en && (state == IDLE) && bus.req;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (lookup) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else if (miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Randomised self-checking bench for icache_assoc against a line-level cache model.
module tb_icache_assoc;
    localparam int ADDR_W = 10, DATA_W = 16, SETS = 4, LINE_WORDS = 8, WAYS = 2;

    logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
    icache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_assoc #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .WAYS(WAYS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clk_en(clk_en),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int mode = 0;         // memory ack pattern: 0 every cycle, 1 every third, 2 random
    bit ce_rand = 1'b0;
    int busy_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] memw(input int a);
        return 16'(a) ^ 16'hA5A5;
    endfunction

    // Cache model: which line sits in which way, replacement pointers, outstanding fill.
    bit          m_vld [SETS][WAYS];
    int          m_tag [SETS][WAYS];
    int          m_rr  [SETS];
    bit          f_act, d_pend, f_flush;
    int          f_base, f_off, f_way, f_k;
    logic [15:0] exp_inst;
    int          done_cnt = 0, m_hits = 0, m_misses = 0;

    task automatic clear_all();
        for (int i = 0; i < SETS; i++)
            for (int j = 0; j < WAYS; j++) m_vld[i][j] = 1'b0;
    endtask

    always @(posedge clk) begin
        int a, s, t, hw, v;
        if (rst) begin
            clear_all();
            for (int i = 0; i < SETS; i++) m_rr[i] = 0;
            f_act = 0; d_pend = 0; f_flush = 0; exp_inst = '0; m_hits = 0; m_misses = 0;
        end else if (clk_en) begin
            if (d_pend) begin
                exp_inst = memw(f_base + f_off);
                if (f_flush || bus.flush) clear_all();
                d_pend = 0; f_flush = 0; done_cnt++;
            end else if (f_act) begin
                if (bus.flush) f_flush = 1;
                if (bus.mem_ack) begin
                    f_k++;
                    if (f_k == LINE_WORDS) begin
                        s = (f_base / LINE_WORDS) % SETS;
                        m_tag[s][f_way] = f_base / (LINE_WORDS * SETS);
                        m_vld[s][f_way] = 1'b1;
                        m_rr[s] = (m_rr[s] + 1) % WAYS;
                        f_act = 0; d_pend = 1;
                    end
                end
            end else begin
                if (bus.flush) clear_all();
                if (bus.req) begin
                    a = int'(bus.addr_in);
                    s = (a / LINE_WORDS) % SETS;
                    t = a / (LINE_WORDS * SETS);
                    hw = -1;
                    for (int w = 0; w < WAYS; w++)
                        if (m_vld[s][w] && m_tag[s][w] == t) hw = w;
                    if (hw >= 0 && !bus.flush) begin
                        exp_inst = memw(a); m_hits++; done_cnt++;
                    end else begin
                        v = -1;
                        for (int w = WAYS - 1; w >= 0; w--) if (!m_vld[s][w]) v = w;
                        if (v < 0) v = m_rr[s];
                        m_misses++;
                        f_act = 1; f_k = 0; f_way = v;
                        f_base = a - (a % LINE_WORDS); f_off = a % LINE_WORDS;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_cyc++;
        chk("busy", 32'(bus.busy), 32'(clk_en && (f_act || d_pend)));
        chk("mem_req", 32'(bus.mem_req), 32'(clk_en && f_act));
        if (clk_en && f_act) chk("mem_addr", 32'(bus.mem_addr), 32'(f_base + f_k));
        chk("inst_out", 32'(bus.inst_out), 32'(exp_inst));
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, 32'(m_hits));
        chk("miss_count", miss_count, 32'(m_misses));
`endif
    end

    // Instruction memory responder.
    int gap = 0;
    always @(negedge clk) begin
        bit ok;
        if (bus.mem_req === 1'b1) begin
            ok = (mode == 2) ? ($urandom_range(0, 1) == 1) : (gap >= ((mode == 1) ? 2 : 0));
            bus.mem_ack = ok;
            bus.mem_data = ok ? (16'(bus.mem_addr) ^ 16'hA5A5) : 16'($urandom);
            gap = ok ? 0 : gap + 1;
        end else begin
            gap = 0;
            bus.mem_ack = (mode == 2) && ($urandom_range(0, 1) == 1);
            bus.mem_data = 16'($urandom);
        end
    end

    always @(posedge clk) begin
        #2;
        clk_en = ce_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
    end

    // Present a fetch until the model retires it; flush pulses on cycle fl_at (-1: none).
    task automatic fetch(input int a, input int fl_at, output int lat);
        int d0, b0, i;
        d0 = done_cnt; b0 = busy_cyc;
        bus.req = 1'b1; bus.addr_in = 10'(a);
        for (i = 0; i < 400 && done_cnt == d0; i++) begin
            bus.flush = (i == fl_at);
            @(posedge clk); #1;
        end
        bus.flush = 1'b0; bus.req = 1'b0;
        lat = busy_cyc - b0 + 1;
        if (done_cnt == d0) begin
            n_chk++;
            $display("FAIL fetch_timeout: addr 0x%0h not retired after %0d cycles", a, i);
        end
    endtask

    initial begin
        int lat;
        bus.req = 1'b0; bus.addr_in = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_inst_out", 32'(bus.inst_out), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);

        fetch(32'h000, -1, lat);
        chk("cold_miss_lat", lat, 32'd10);
        chk("cold_miss_word", 32'(bus.inst_out), 32'hA5A5);
        fetch(32'h003, -1, lat);
        chk("hit_lat", lat, 32'd1);
        chk("hit_word", 32'(bus.inst_out), 32'hA5A6);

        fetch(32'h020, -1, lat);  chk("fill_020_lat", lat, 32'd10);
        fetch(32'h040, -1, lat);  chk("evict_040_lat", lat, 32'd10);
        fetch(32'h020, -1, lat);  chk("rehit_020_lat", lat, 32'd1);
        fetch(32'h000, -1, lat);  chk("evicted_000_lat", lat, 32'd10);

        mode = 1;
        fetch(32'h080, -1, lat);
        chk("slow_mem_lat", lat, 32'd26);
        chk("slow_mem_word", 32'(bus.inst_out), 32'hA525);
        mode = 0;

        fetch(32'h100, 3, lat);
        chk("flush_fill_lat", lat, 32'd10);
        chk("flush_fill_word", 32'(bus.inst_out), 32'hA4A5);
        fetch(32'h100, -1, lat);  chk("after_flush_miss", lat, 32'd10);
        fetch(32'h100, -1, lat);  chk("refill_hit", lat, 32'd1);
        fetch(32'h100, 0, lat);   chk("idle_flush_req_miss", lat, 32'd10);

        bus.req = 1'b1; bus.addr_in = 10'h200;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.req = 1'b0;
        fetch(32'h200, -1, lat);  chk("rst_abort_miss", lat, 32'd10);

`ifdef ICACHE_STATS_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fetch(32'h000, -1, lat); fetch(32'h001, -1, lat); fetch(32'h002, -1, lat);
        fetch(32'h040, -1, lat); fetch(32'h041, -1, lat);
        chk("stats_hits", hit_count, 32'd3);
        chk("stats_misses", miss_count, 32'd2);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("stats_hits_flush", hit_count, 32'd3);
        chk("stats_misses_flush", miss_count, 32'd2);
`endif

        ce_rand = 1'b1; mode = 2;
        for (int n = 0; n < 300; n++) begin
            int a, fa;
            a  = ($urandom_range(0, 2) * SETS * LINE_WORDS) + ($urandom_range(0, 3) * LINE_WORDS)
                 + $urandom_range(0, 7);
            fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : -1;
            fetch(a, fa, lat);
        end
        ce_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
